// File: rtl/spectral_bin_resampler.sv
// spectral_bin_resampler: captures FFT frames into a ping-pong buffer and
// replays each one in bin order, output bin k taken from source floor(k*step).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   fft_data/user/valid   input bin word, bin index (write address), beat valid
//   fft_last, fft_ready   end of input frame, input backpressure
//   scale_factor(_valid)  unsigned Q(STEP_W-STEP_FRAC).STEP_FRAC step, latched per frame
//   data_out, output_k    resampled bin word and its output bin index
//   output_valid/last     output beat valid, asserted with output_k == N-1
//   output_ready          output backpressure
module spectral_bin_resampler #(
  parameter int N_LOG2    = 11,
  parameter int DATA_W    = 80,
  parameter int STEP_W    = 24,
  parameter int STEP_FRAC = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fft_data,
  input  logic [N_LOG2-1:0] fft_user,
  input  logic              fft_valid,
  input  logic              fft_last,
  output logic              fft_ready,
  input  logic [STEP_W-1:0] scale_factor,
  input  logic              scale_factor_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [N_LOG2-1:0] output_k,
  output logic              output_valid,
  output logic              output_last,
  input  logic              output_ready
);

  localparam int N     = 1 << N_LOG2;
  localparam int ACC_W = N_LOG2 + STEP_W;
  localparam int SRC_LO = STEP_FRAC;
  localparam int OOR_LO = STEP_FRAC + N_LOG2;

  localparam logic [N_LOG2-1:0] K_LAST   = N_LOG2'(N - 1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1 << STEP_FRAC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  // ---------------- buffer ownership ----------------
  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;

  // ---------------- read issue FSM ----------------
  state_e            state_q, state_d;
  logic [N_LOG2-1:0] k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [STEP_W-1:0] step_q, step_d;

  // ---------------- RAM stage ----------------
  logic              s1_valid_q;
  logic [N_LOG2-1:0] s1_k_q;
  logic              s1_zero_q;
  logic              s1_last_q;
  logic [DATA_W-1:0] rd_data_q;

  // ---------------- output stage ----------------
  logic              out_valid_q;
  logic [N_LOG2-1:0] out_k_q;
  logic              out_last_q;
  logic [DATA_W-1:0] out_data_q;

  logic [DATA_W-1:0] mem_q [2*N];

  logic              wr_fire;
  logic              rel;
  logic              out_en;
  logic              s1_en;
  logic              issue;
  logic              src_oor;
  logic [N_LOG2-1:0] src_addr;

  assign fft_ready = !full_q[wr_bank_q];
  assign wr_fire   = fft_valid && fft_ready;

  // The read bank is only handed back once its final beat leaves the
  // output register, so nothing in flight can be overwritten.
  assign rel = out_valid_q && output_ready && out_last_q;

  // Stall chain: each stage advances only when the one after it can take
  // its word, so a stalled beat is held in place rather than re-read.
  assign out_en = !out_valid_q || output_ready;
  assign s1_en  = !s1_valid_q || out_en;
  assign issue  = (state_q == S_RUN) && s1_en;

  assign src_addr = acc_q[SRC_LO +: N_LOG2];
  assign src_oor  = |acc_q[ACC_W-1:OOR_LO];

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire && fft_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
    // Write and read always own opposite banks, so both may update at once.
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    step_d  = step_q;
    unique case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = S_RUN;
          k_d     = '0;
          acc_d   = '0;
          if (scale_factor_valid) begin
            step_d = scale_factor;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          k_d   = k_q + N_LOG2'(1);
          acc_d = acc_q + ACC_W'(step_q);
          if (k_q == K_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (rel) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      state_q   <= S_IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      step_q    <= STEP_ONE;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
    end
  end

  // Buffer RAM: both banks in one array, bank select is the top address bit.
  // The read port only fires on issue, so its word holds while stalled.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[{wr_bank_q, fft_user}] <= fft_data;
    end
    if (issue) begin
      rd_data_q <= mem_q[{rd_bank_q, src_addr}];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_k_q     <= '0;
      s1_zero_q  <= 1'b0;
      s1_last_q  <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= issue;
      if (issue) begin
        s1_k_q    <= k_q;
        s1_zero_q <= src_oor;
        s1_last_q <= (k_q == K_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_k_q     <= '0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (out_en) begin
      out_valid_q <= s1_valid_q;
      out_last_q  <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_k_q    <= s1_k_q;
        out_data_q <= s1_zero_q ? '0 : rd_data_q;
      end
    end
  end

  assign data_out     = out_data_q;
  assign output_k     = out_k_q;
  assign output_valid = out_valid_q;
  assign output_last  = out_last_q;

endmodule

// File: tb/tb_spectral_bin_resampler.sv
// Self-checking bench for spectral_bin_resampler: step table, back-to-back
// backpressure, random stalls, step latching and mid-frame reset.
module tb_spectral_bin_resampler;

  localparam int NL = 11;
  localparam int DW = 80;
  localparam int SW = 24;
  localparam int SF = 20;
  localparam int N  = 1 << NL;

  logic          clk;
  logic          rst;
  logic [DW-1:0] fft_data;
  logic [NL-1:0] fft_user;
  logic          fft_valid;
  logic          fft_last;
  logic          fft_ready;
  logic [SW-1:0] scale_factor;
  logic          scale_factor_valid;
  logic [DW-1:0] data_out;
  logic [NL-1:0] output_k;
  logic          output_valid;
  logic          output_last;
  logic          output_ready;

  spectral_bin_resampler #(
    .N_LOG2(NL), .DATA_W(DW), .STEP_W(SW), .STEP_FRAC(SF)
  ) dut (
    .clk(clk), .rst(rst),
    .fft_data(fft_data), .fft_user(fft_user),
    .fft_valid(fft_valid), .fft_last(fft_last), .fft_ready(fft_ready),
    .scale_factor(scale_factor), .scale_factor_valid(scale_factor_valid),
    .data_out(data_out), .output_k(output_k),
    .output_valid(output_valid), .output_last(output_last),
    .output_ready(output_ready)
  );

  typedef struct {
    logic [NL-1:0] k;
    logic [DW-1:0] d;
    logic          l;
    int            t;
  } beat_t;

  typedef struct {
    logic [SW-1:0] step;
    int            k;
    logic [DW-1:0] exp;
  } vec_t;

  beat_t         q[$];
  logic [DW-1:0] cap [N];
  vec_t          tab [13];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            ready_mode = 0;
  int            last_t = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    output_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: output_ready = 1'b0;
        1: output_ready = 1'b1;
        default: output_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  function automatic logic [DW-1:0] in_word(input int fid, input longint u);
    logic [31:0] h;
    h = 32'(fid) * 32'h9E3779B1 * 32'(u + 1);
    return {16'(fid), h, 32'(2 * u)};
  endfunction

  // Reference: output bin k comes from source bin floor(k*step / 2^SF),
  // zero when that source lies beyond the frame.
  function automatic logic [DW-1:0] exp_word(input int fid,
                                              input logic [SW-1:0] st,
                                              input int k);
    longint src;
    src = (longint'(k) * longint'(st)) >> SF;
    if (src >= N) return '0;
    return in_word(fid, src);
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input int fid, input int nb, input bit gaps,
                            output int e0);
    bit r;
    int w;
    e0 = -1;
    @(posedge clk);
    #1;
    for (int u = 0; u < nb; u++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        fft_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      fft_valid = 1'b1;
      fft_user  = NL'(u);
      fft_data  = in_word(fid, u);
      fft_last  = (u == N - 1);
      w = 0;
      do begin
        @(negedge clk);
        r = fft_ready;
        @(posedge clk);
        #1;
        w++;
      end while (!r && w < 20000);
      if (!r) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout fid=%0d: beat %0d not accepted", fid, u);
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        return;
      end
    end
    e0 = cyc;
    fft_valid = 1'b0;
    fft_last  = 1'b0;
  endtask

  task automatic check_frame(input int fid, input logic [SW-1:0] st,
                             input int e0, input int maxgap);
    int w, bk, bd, bl, fk;
    beat_t b;
    logic [DW-1:0] e, fg, fe;
    w = 0;
    while (q.size() < N && w < 20000) begin
      @(posedge clk);
      w++;
    end
    if (q.size() < N) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout fid=%0d: got %0d beats want %0d",
               fid, q.size(), N);
      q.delete();
      return;
    end
    bk = 0; bd = 0; bl = 0; fk = -1; fg = '0; fe = '0;
    for (int i = 0; i < N; i++) begin
      b = q.pop_front();
      if (i == 0) begin
        if (e0 >= 0) chk("latency", DW'(b.t), DW'(e0 + 3));
        if (maxgap >= 0) begin
          n_cmp++;
          if (b.t - last_t > maxgap) begin
            n_bad++;
            $display("FAIL frame_gap fid=%0d: got %0d cycles want <= %0d",
                     fid, b.t - last_t, maxgap);
          end
        end
      end
      if (b.k != NL'(i)) bk++;
      if (b.l != (i == N - 1)) bl++;
      e = exp_word(fid, st, i);
      cap[i] = b.d;
      if (b.d !== e) begin
        if (fk < 0) begin fk = i; fg = b.d; fe = e; end
        bd++;
      end
      if (i == N - 1) last_t = b.t;
    end
    n_cmp++;
    if (bk != 0) begin
      n_bad++;
      $display("FAIL frame_k_order fid=%0d: got %0d out-of-order beats want 0",
               fid, bk);
    end
    n_cmp++;
    if (bl != 0) begin
      n_bad++;
      $display("FAIL frame_last fid=%0d: got %0d misplaced last flags want 0",
               fid, bl);
    end
    n_cmp++;
    if (bd != 0) begin
      n_bad++;
      $display("FAIL frame_data fid=%0d: %0d bad, first k=%0d got %h want %h",
               fid, bd, fk, fg, fe);
    end
  endtask

  logic [DW-1:0] pd;
  logic [NL-1:0] pk;
  logic          pl;
  bit            pstall;

  initial begin
    int e0;
    int dummy;
    bit have;
    logic [SW-1:0] cur, rs, ra, rb;

    rst = 1'b1;
    fft_data = '0; fft_user = '0; fft_valid = 1'b0; fft_last = 1'b0;
    scale_factor = '0; scale_factor_valid = 1'b0;
    pstall = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
          pstall = 1'b0;
        end else begin
          if (pstall) begin
            n_cmp++;
            if (!output_valid || data_out !== pd || output_k !== pk ||
                output_last !== pl) begin
              n_bad++;
              $display("FAIL stall_hold: got v=%b k=%0d d=%h want v=1 k=%0d d=%h",
                       output_valid, output_k, data_out, pk, pd);
            end
          end
          if (output_valid && output_ready) begin
            beat_t b;
            b.k = output_k; b.d = data_out; b.l = output_last; b.t = cyc;
            q.push_back(b);
          end
          pstall = output_valid && !output_ready;
          pd = data_out; pk = output_k; pl = output_last;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_fft_ready", DW'(fft_ready), DW'(1));
    chk("rst_valid", DW'(output_valid), DW'(0));
    chk("rst_last", DW'(output_last), DW'(0));
    chk("rst_k", DW'(output_k), DW'(0));
    chk("rst_data", data_out, DW'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    ready_mode = 1;

    tab[0]  = '{24'h100000,    0, 80'd0};
    tab[1]  = '{24'h100000,    5, 80'd10};
    tab[2]  = '{24'h100000, 2047, 80'd4094};
    tab[3]  = '{24'h080000,    5, 80'd4};
    tab[4]  = '{24'h080000, 2047, 80'd2046};
    tab[5]  = '{24'h200000,    5, 80'd20};
    tab[6]  = '{24'h200000, 1023, 80'd4092};
    tab[7]  = '{24'h200000, 1024, 80'd0};
    tab[8]  = '{24'h200000, 2047, 80'd0};
    tab[9]  = '{24'h0C0000,    5, 80'd6};
    tab[10] = '{24'h0C0000, 2047, 80'd3070};
    tab[11] = '{24'h180000, 1365, 80'd4094};
    tab[12] = '{24'h180000, 1366, 80'd0};

    have = 1'b0;
    cur = '0;
    for (int i = 0; i < 13; i++) begin
      if (!have || tab[i].step != cur) begin
        cur = tab[i].step;
        have = 1'b1;
        scale_factor = cur;
        scale_factor_valid = 1'b1;
        send_frame(0, N, 1'b0, e0);
        check_frame(0, cur, e0, -1);
      end
      chk($sformatf("table[%0d]", i), cap[tab[i].k], tab[i].exp);
    end

    // Back-to-back frames against a stalled output.
    ready_mode = 0;
    rs = SW'($urandom_range(0, 24'h2FFFFF));
    scale_factor = rs;
    scale_factor_valid = 1'b1;
    send_frame(1, N, 1'b0, dummy);
    send_frame(2, N, 1'b0, dummy);
    chk("bp_ready_low", DW'(fft_ready), DW'(0));
    fork
      send_frame(3, N, 1'b0, dummy);
      begin
        repeat (5000) @(posedge clk);
        #3;
        chk("bp_hold_valid", DW'(output_valid), DW'(1));
        chk("bp_hold_k", DW'(output_k), DW'(0));
        chk("bp_hold_ready", DW'(fft_ready), DW'(0));
        ready_mode = 1;
      end
    join
    check_frame(1, rs, -1, -1);
    check_frame(2, rs, -1, 4);
    check_frame(3, rs, -1, 4);

    // Step latch with random output stalls.
    ready_mode = 2;
    ra = SW'($urandom_range(0, 24'h3FFFFF));
    scale_factor = ra;
    scale_factor_valid = 1'b1;
    send_frame(4, N, 1'b0, dummy);
    for (int w = 0; w < 5000 && q.size() < 100; w++) @(posedge clk);
    #1;
    scale_factor = ra ^ 24'h2A5A5A;
    scale_factor_valid = 1'b0;
    send_frame(5, N, 1'b0, dummy);
    check_frame(4, ra, -1, -1);
    check_frame(5, ra, -1, -1);

    rb = SW'($urandom_range(0, 24'h3FFFFF));
    scale_factor = rb;
    scale_factor_valid = 1'b1;
    send_frame(6, N, 1'b1, dummy);
    check_frame(6, rb, -1, -1);

    scale_factor = '0;
    send_frame(7, N, 1'b1, dummy);
    check_frame(7, 24'h0, -1, -1);

    // Reset in the middle of a stalled output frame and a partial input.
    ready_mode = 0;
    scale_factor = 24'h080000;
    scale_factor_valid = 1'b1;
    send_frame(20, N, 1'b0, dummy);
    scale_factor_valid = 1'b0;
    send_frame(21, 1000, 1'b0, dummy);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", DW'(output_valid), DW'(0));
    chk("mid_rst_last", DW'(output_last), DW'(0));
    chk("mid_rst_k", DW'(output_k), DW'(0));
    chk("mid_rst_data", data_out, DW'(0));
    chk("mid_rst_fft_ready", DW'(fft_ready), DW'(1));
    @(posedge clk);
    #2;
    rst = 1'b0;
    ready_mode = 1;
    send_frame(22, N, 1'b0, e0);
    check_frame(22, 24'h100000, e0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spectral_bin_resampler.md
# spectral_bin_resampler

Parametrised, frame-buffered successor to the single-frame FFT bin resampler; sits between the forward FFT and the inverse FFT in the pitch-shift path. Captures a full frame of FFT bins into a ping-pong buffer, then emits the frame in bin order with each output bin k taken from source bin floor(k·step). Out-of-range source bins are replaced with zero. Unlike the previous resampler, it accepts a new input frame while it emits the previous one, applies output backpressure, and exerts input backpressure when both buffers are full.

## Interface
- N_LOG2, 11, log2 of FFT length N (bins per frame)
- DATA_W, 80, bin word width (opaque; packed re/im, passed through unmodified)
- STEP_W, 24, width of step word
- STEP_FRAC, 20, fractional bits of step (1.0 = 2^STEP_FRAC = 24'h100000 at defaults)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- fft_data  in  DATA_W  input bin value
- fft_user  in  N_LOG2  input bin index (write address)
- fft_valid  in  1  input beat valid
- fft_last  in  1  final beat of input frame
- fft_ready  out  1  input beat accepted when fft_valid && fft_ready
- scale_factor  in  STEP_W  unsigned step, Q(STEP_W-STEP_FRAC).STEP_FRAC
- scale_factor_valid  in  1  scale_factor usable this cycle
- data_out  out  DATA_W  output bin value
- output_k  out  N_LOG2  output bin index
- output_valid  out  1  output beat valid
- output_last  out  1  asserted with output_k == N-1
- output_ready  in  1  output beat consumed when output_valid && output_ready

## Operation
- Two banks of N×DATA_W each, plus full[1:0], wr_bank, rd_bank. All are 0 at reset.
- Write side: an accepted beat writes fft_data to bank[wr_bank][fft_user]. An accepted beat with fft_last set sets full[wr_bank] and toggles wr_bank. The frame ends on fft_last regardless of beat count; unwritten addresses keep stale contents.
- fft_ready = !full[wr_bank].
- Read FSM:
  - IDLE: when full[rd_bank], latch step, clear k and acc, go to RUN.
  - RUN: issue addresses k = 0..N-1, advancing only when the pipeline can accept. When the beat with k = N-1 is handshaken, clear full[rd_bank], toggle rd_bank, go to IDLE.
- Step latch: at each IDLE→RUN transition, step_q ← scale_factor if scale_factor_valid, else step_q keeps its previous value. step_q resets to 1<<STEP_FRAC. Step is constant for a whole output frame.
- Address arithmetic:
  - acc has width N_LOG2+(STEP_W-STEP_FRAC)+STEP_FRAC; acc = k·step_q, formed by accumulation (acc += step_q per issued bin, no multiplier).
  - src = acc >> STEP_FRAC.
  - If src ≥ N (any bit above N_LOG2 set), the output word is all zeros and the RAM read is don't-care. Otherwise data_out = bank[rd_bank][src].
- step_q = 0: every output bin equals input bin 0.
- Simultaneous write completion on one bank and read release of the other bank in the same cycle: both updates take effect; no conflict.
- Write and read never target the same bank concurrently, because full gates both sides.

## Timing
- Reset values: fft_ready = 1, output_valid = 0, output_last = 0, output_k = 0, data_out = 0.
- Synchronous RAM read, 1 cycle.
- Pipeline: issue → RAM → output register.
- Latency, with the FSM idle and output_ready = 1: fft_last accepted at edge E0; IDLE→RUN at E1; first output_valid (k=0) is registered at E3.
- Throughput: 1 bin/cycle while output_ready = 1.
- A new frame's k=0 appears 3 cycles after the previous output_last handshake when the other bank is already full.
- Backpressure: while output_valid && !output_ready, data_out, output_k and output_last are held stable. No beat is dropped or duplicated; the in-flight RAM word is held (skid register) or re-read.
- fft_ready deasserts the cycle after the second bank fills and reasserts the cycle after a read bank is released.
- rst mid-frame: immediate asynchronous return to reset values. Partial frames are discarded; step_q returns to 1.0.

## Test plan
- Identity: fft_data = 2·fft_user, step 24'h100000, one frame of 2048 beats with output_ready = 1 → output_k 0..2047, data_out = 2·k, output_last only at k = 2047, first valid 3 cycles after fft_last.
- Pitch up: step 24'h080000 (0.5) → data_out = 2·floor(k/2); k = 5 gives 4. Pitch down: step 24'h200000 → k < 1024 gives data_out = 4·k; k ≥ 1024 gives 0.
- Back-to-back: three frames sent with fft_valid held high, output_ready = 0 for 5000 cycles → fft_ready drops after frame 2 completes. After release, all three frames emerge in order, with no gaps greater than 3 cycles between them.
- Random output_ready (50%): every k is emitted exactly once per frame, and outputs stay stable while stalled.
- Step latch: scale_factor changed mid-output-frame, and scale_factor_valid = 0 at a frame start → the current frame is unaffected, and the next frame uses the last valid latched step.
- Async rst asserted mid-frame for one cycle → outputs return to reset values immediately, fft_ready = 1, and the next full frame resamples correctly.
